prog_lut_neuron: RTL
====================

Name: prog_lut_neuron

Overview:
- Runtime-programmable successor to the fixed, generated truth-table neurons: one neuron whose table (2^IN_W entries of OUT_W bits) is loaded over a config stream instead of being baked into RTL.
- Adds a registered, valid/ready-handshaked inference path, so the neuron can be chained in a pipelined layer and reprogrammed without resynthesis.
- Sits between the input-quantiser/fan-in mux and the next layer's neuron inputs.

Parameters:
- IN_W, 8, neuron fan-in bit width; the table holds 2^IN_W entries.
- OUT_W, 1, output activation bit width (bits per table entry).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- cfg_start  in  1  pulse: begin a (re)load; write address returns to 0.
- cfg_valid  in  1  cfg_data valid.
- cfg_data  in  OUT_W  table entry for the current load address.
- cfg_ready  out  1  load is accepting entries.
- cfg_done  out  1  table fully loaded; high while in RUN.
- in_valid  in  1  in_data valid.
- in_ready  out  1  neuron accepts in_data.
- in_data  in  IN_W  table index (activation inputs, LSB = input 0).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  OUT_W  looked-up activation.

Behaviour:
- State machine states: EMPTY, LOAD, RUN. Reset state is EMPTY.
- Reset values: cfg_ready=0, cfg_done=0, in_ready=0, out_valid=0, out_data=0, load address=0.
- Table storage is not reset. Its contents are undefined until the first full load.
- EMPTY:
  - cfg_start moves to LOAD and clears the address.
  - cfg_valid is ignored.
- LOAD:
  - cfg_ready=1.
  - Each cycle with cfg_valid=1 writes cfg_data to table[addr] and increments addr.
  - The write at addr = 2^IN_W-1 moves to RUN on the next edge; addr wraps to 0.
  - cfg_start in LOAD restarts at addr 0. It takes priority over a same-cycle cfg_valid, so that entry is dropped.
- RUN:
  - cfg_done=1.
  - cfg_valid is ignored.
  - cfg_start moves to LOAD: cfg_done drops and in_ready drops on the next cycle.
- Inference:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - A transfer occurs when in_valid && in_ready. On the next edge, out_data = table[in_data] and out_valid=1. Latency is 1 cycle.
  - out_valid clears on out_valid && out_ready with no new transfer in the same cycle.
  - A transfer with out_ready=1 and out_valid=1 replaces the output in the same edge, giving full throughput.
  - While out_valid=1 and out_ready=0, out_data holds stable.
- Reprogramming with a pending output: the held out_valid/out_data stays until accepted, even across LOAD. No new inputs are taken until RUN.
- Address arithmetic is IN_W-bit unsigned and wraps modulo 2^IN_W.
- Read and write during LOAD: no reads occur, because in_ready=0.
- Reset mid-load:
  - state→EMPTY, addr→0, out_valid→0.
  - Partially written entries persist but are unusable until a full reload.
- Parameter rule: IN_W must be in the range 1..12; elaboration errors otherwise.

Decomposition:
- Shared package lut_neuron_pkg holds:
  - the state enum (EMPTY, LOAD, RUN);
  - the derived constant TABLE_DEPTH = 1<<IN_W (as a function of IN_W).
- Sub-module lut_table_ram (distributed-RAM style):
  - 1 synchronous write port and 1 asynchronous read port;
  - parameters IN_W and OUT_W;
  - no reset on storage.
  - The output register and handshake live in the top level.

Test Plan:
- Reset with in_valid=1 and cfg_valid=1 → in_ready=0, cfg_ready=0, out_valid=0, cfg_done=0.
- IN_W=8, OUT_W=1:
  - Stimulus: cfg_start, then 256 entries with table[i]=parity(i), then inputs 0x00, 0x01, 0x03, 0xFF with out_ready=1.
  - Required: cfg_done rises one cycle after the 256th write; outputs are 0, 1, 0, 0, each 1 cycle after acceptance, back-to-back.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles with in_valid=1, in_data=0x01.
  - Required: a single out_valid with out_data=1, stable throughout; in_ready=0 after the first transfer. Releasing out_ready gives one transfer per cycle.
- Reload mid-stream:
  - Stimulus: in RUN, cfg_start while out_valid=1 and out_ready=0; then load the complement table.
  - Required: the held output stays 1 until accepted; in_ready=0 through LOAD; after reload, in_data=0x01 → out_data=0.
- Restart and ignored writes:
  - Stimulus: cfg_start after 100 writes, then a full 256-entry load; also cfg_valid pulses in RUN.
  - Required: the restart makes address 0 the next write; the full load completes normally; cfg_valid in RUN leaves the table unchanged.
- Asynchronous reset:
  - Stimulus: rst_n asserted asynchronously mid-LOAD (between clock edges), then released.
  - Required: outputs drop immediately; state is EMPTY after release; in_ready=0 until a fresh full load completes.

Source files
------------

// File: rtl/lut_neuron_pkg.sv
// Shared types and derived constants for the programmable LUT neuron.
package lut_neuron_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam int unsigned MAX_IN_W = 12;

    function automatic int unsigned table_depth(input int unsigned in_w);
        return 32'd1 << in_w;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Truth-table storage: one synchronous write port, one asynchronous read port, no reset.
module lut_table_ram
    import lut_neuron_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IN_W-1:0]  waddr_i,
    input  logic [OUT_W-1:0] wdata_i,
    input  logic [IN_W-1:0]  raddr_i,
    output logic [OUT_W-1:0] rdata_o
);

    localparam int unsigned TABLE_DEPTH = table_depth(IN_W);

    logic [OUT_W-1:0] mem_q [TABLE_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_lut_neuron.sv
// Runtime-loadable truth-table neuron with a registered valid/ready inference stage.
module prog_lut_neuron
    import lut_neuron_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_start_i,
    input  logic             cfg_valid_i,
    input  logic [OUT_W-1:0] cfg_data_i,
    output logic             cfg_ready_o,
    output logic             cfg_done_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o
);

    generate
        if (IN_W < 1 || IN_W > MAX_IN_W) begin : g_bad_in_w
            $error("prog_lut_neuron: IN_W must be within 1..12");
        end
    endgenerate

    localparam logic [IN_W-1:0] LAST_ADDR = '1;

    state_e           state_q, state_d;
    logic [IN_W-1:0]  addr_q, addr_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             cfg_done_q, cfg_done_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             table_we;
    logic [OUT_W-1:0] rd_data;
    logic             in_ready;
    logic             in_xfer;

    lut_table_ram #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_table (
        .clk_i   (clk_i),
        .we_i    (table_we),
        .waddr_i (addr_q),
        .wdata_i (cfg_data_i),
        .raddr_i (in_data_i),
        .rdata_o (rd_data)
    );

    // A restart in LOAD wins over a same-cycle entry, which is dropped.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        table_we = 1'b0;
        case (state_q)
            EMPTY: begin
                if (cfg_start_i) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end
            end
            LOAD: begin
                if (cfg_start_i) begin
                    addr_d = '0;
                end else if (cfg_valid_i) begin
                    table_we = 1'b1;
                    addr_d   = addr_q + IN_W'(1);
                    if (addr_q == LAST_ADDR) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cfg_start_i) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = EMPTY;
                addr_d  = '0;
            end
        endcase
        cfg_ready_d = (state_d == LOAD);
        cfg_done_d  = (state_d == RUN);
    end

    assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready_i);
    assign in_xfer  = in_valid_i && in_ready;

    // A pending result is held until accepted, even across a reload.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            addr_q      <= '0;
            cfg_ready_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_done_q  <= cfg_done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign cfg_ready_o = cfg_ready_q;
    assign cfg_done_o  = cfg_done_q;
    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule
